// File: rtl/uart_ctrl.sv
// Console-side uart controller: round-robin TX arbitration plus RX drain into a FIFO.
// Define UART_CTRL_RX_FIFO_EN for the 2**FIFO_DEPTH_LOG2 FIFO; otherwise RX uses one holding register.
module uart_ctrl #(
  parameter int NUM_REQ         = 3,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic                 raw_clk,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_grant,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_strobe,
  input  logic                 uart_tx_busy,
  input  logic [7:0]           uart_rx_data,
  input  logic                 uart_rx_ready,
  output logic                 uart_rx_ready_clear,
  output logic [7:0]           rx_data,
  output logic                 rx_valid,
  input  logic                 rx_pop,
  output logic                 rx_overflow,
  input  logic                 rx_overflow_clear
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 1 || NUM_REQ > 8 || FIFO_DEPTH_LOG2 < 1) begin : g_bad_param
    $error("uart_ctrl: NUM_REQ must be 1..8 and FIFO_DEPTH_LOG2 at least 1");
  end

  typedef enum logic [1:0] {
    IDLE,
    STROBE,
    WAIT_START,
    WAIT_DONE
  } tx_state_t;

  tx_state_t            state_q, state_d;
  logic [SEL_W-1:0]     last_q;
  logic [SEL_W-1:0]     sel;
  logic [SEL_W:0]       cand;
  logic                 any_valid;
  logic                 take;
  logic [NUM_REQ-1:0]   grant_d;

  // Circular search starting one past the last winner; the extra cand bit absorbs the wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    sel       = last_q;
    any_valid = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_q} + (SEL_W+1)'(k);
      if (cand >= (SEL_W+1)'(NUM_REQ)) begin
        cand = cand - (SEL_W+1)'(NUM_REQ);
      end
      if (!any_valid && req_valid[cand[SEL_W-1:0]]) begin
        any_valid = 1'b1;
        sel       = cand[SEL_W-1:0];
      end
    end
    grant_d      = '0;
    grant_d[sel] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!uart_tx_busy && any_valid) begin
          take    = 1'b1;
          state_d = STROBE;
        end
      end
      STROBE:     state_d = WAIT_START;
      WAIT_START: if (uart_tx_busy)  state_d = WAIT_DONE;
      WAIT_DONE:  if (!uart_tx_busy) state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge raw_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Strobe and grant are registered from the IDLE decision, so they are high only in STROBE.
  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      uart_tx_strobe <= 1'b0;
      req_grant      <= '0;
      uart_tx_data   <= '0;
      last_q         <= SEL_W'(NUM_REQ - 1);
    end else begin
      uart_tx_strobe <= take;
      req_grant      <= take ? grant_d : '0;
      if (take) begin
        uart_tx_data <= req_data[8*sel +: 8];
        last_q       <= sel;
      end
    end
  end

  // The uart flag is still high during our clear cycle, so the clear itself masks a re-capture.
  logic capture, push, pop_eff, drop;
  assign capture = uart_rx_ready && !uart_rx_ready_clear;
  assign drop    = capture && !push;

  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      uart_rx_ready_clear <= 1'b0;
      rx_overflow         <= 1'b0;
    end else begin
      uart_rx_ready_clear <= capture;
      if (drop) begin
        rx_overflow <= 1'b1;
      end else if (rx_overflow_clear) begin
        rx_overflow <= 1'b0;
      end
    end
  end

`ifdef UART_CTRL_RX_FIFO_EN
  localparam logic [FIFO_DEPTH_LOG2:0] DEPTH = (FIFO_DEPTH_LOG2+1)'(1 << FIFO_DEPTH_LOG2);

  logic [7:0]                 mem [1 << FIFO_DEPTH_LOG2];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic                       empty, full;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign pop_eff = rx_pop && !empty;
  assign push    = capture && (!full || pop_eff);

  // NOTE: storage is not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge raw_clk) begin
    if (push) begin
      mem[wr_ptr] <= uart_rx_data;
    end
  end

  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)    wr_ptr <= wr_ptr + 1'b1;
      if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop_eff})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign rx_data  = mem[rd_ptr];
  assign rx_valid = !empty;
`else
  logic [7:0] hold_q;
  logic       hold_valid_q;

  assign pop_eff = rx_pop && hold_valid_q;
  assign push    = capture && (!hold_valid_q || pop_eff);

  always_ff @(posedge raw_clk) begin
    if (!reset_n) begin
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
    end else begin
      if (push) begin
        hold_q       <= uart_rx_data;
        hold_valid_q <= 1'b1;
      end else if (pop_eff) begin
        hold_valid_q <= 1'b0;
      end
    end
  end

  assign rx_data  = hold_q;
  assign rx_valid = hold_valid_q;
`endif

endmodule

// File: tb/tb_uart_ctrl.sv
// Self-checking bench for uart_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model (circular-priority arbiter, byte queue, sticky overflow flag).
module tb_uart_ctrl;

  localparam int N     = 3;
  localparam int FLOG2 = 3;
`ifdef UART_CTRL_RX_FIFO_EN
  localparam int DEPTH = 1 << FLOG2;
`else
  localparam int DEPTH = 1;
`endif

  logic           raw_clk;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_grant;
  logic [7:0]     uart_tx_data;
  logic           uart_tx_strobe;
  logic           uart_tx_busy;
  logic [7:0]     uart_rx_data;
  logic           uart_rx_ready;
  logic           uart_rx_ready_clear;
  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           rx_pop;
  logic           rx_overflow;
  logic           rx_overflow_clear;

  uart_ctrl #(.NUM_REQ(N), .FIFO_DEPTH_LOG2(FLOG2)) dut (
    .raw_clk             (raw_clk),
    .reset_n             (reset_n),
    .req_valid           (req_valid),
    .req_data            (req_data),
    .req_grant           (req_grant),
    .uart_tx_data        (uart_tx_data),
    .uart_tx_strobe      (uart_tx_strobe),
    .uart_tx_busy        (uart_tx_busy),
    .uart_rx_data        (uart_rx_data),
    .uart_rx_ready       (uart_rx_ready),
    .uart_rx_ready_clear (uart_rx_ready_clear),
    .rx_data             (rx_data),
    .rx_valid            (rx_valid),
    .rx_pop              (rx_pop),
    .rx_overflow         (rx_overflow),
    .rx_overflow_clear   (rx_overflow_clear)
  );

  initial raw_clk = 1'b0;
  always #5 raw_clk = ~raw_clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [7:0] rxq[$];
  bit         m_ovf;
  int         rr_last;
  bit         tx_out;
  logic [7:0] last_data;
  bit         exp_clear;
  bit         rx_new;
  int         idle_wait, max_idle, n_strobes;
  // Uart transmitter model
  int         busy_cnt;
  bit         start_pending;
  int         frame_len;
  // Directed-test scratch
  logic [7:0] got[$];
  logic [7:0] rr_exp [4];
  logic [7:0] lat_b, lastb;
  int         nclr, nbusy, npop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: sample inputs, let the edge happen, update the model, check at the negedge.
  task automatic tick();
    logic [N-1:0]   rv;
    logic [8*N-1:0] rd;
    logic [7:0]     rxd;
    bit cap, pop, ovc, rst, clr_now, busy_e, tx_out_e, ovf_set;
    int exp_sel, idx;
    rv = req_valid; rd = req_data; rxd = uart_rx_data; cap = rx_new; pop = rx_pop;
    ovc = rx_overflow_clear; rst = !reset_n; clr_now = uart_rx_ready_clear;
    busy_e = uart_tx_busy; tx_out_e = tx_out;
    @(posedge raw_clk);
    #1;
    if (clr_now) uart_rx_ready = 1'b0;
    rx_new = 1'b0;
    if (rst) begin
      rxq.delete(); m_ovf = 0; rr_last = N - 1; tx_out = 0; last_data = 8'h00;
      exp_clear = 0; idle_wait = 0;
    end else begin
      if (pop && rxq.size() > 0) void'(rxq.pop_front());
      ovf_set = 0;
      if (cap) begin
        if (rxq.size() < DEPTH) rxq.push_back(rxd);
        else ovf_set = 1;
      end
      if (ovf_set) m_ovf = 1;
      else if (ovc) m_ovf = 0;
      exp_clear = cap;
    end
    @(negedge raw_clk);
    if (rst) begin
      check("rst_strobe", uart_tx_strobe, 0);
      check("rst_grant", req_grant, 0);
      check("rst_tx_data", uart_tx_data, 0);
    end else if (uart_tx_strobe) begin
      n_strobes++;
      check("tx_busy_at_start", busy_e, 0);
      check("tx_one_in_flight", tx_out_e, 0);
      exp_sel = -1;
      for (int k = 1; k <= N; k++) begin
        idx = (rr_last + k) % N;
        if (exp_sel < 0 && rv[idx]) exp_sel = idx;
      end
      if (exp_sel < 0) begin
        check("tx_spurious_strobe", uart_tx_strobe, 0);
      end else begin
        check("tx_grant", req_grant, 32'(1) << exp_sel);
        last_data = rd[8*exp_sel +: 8];
        check("tx_data", uart_tx_data, last_data);
        rr_last = exp_sel;
      end
      tx_out = 1; idle_wait = 0;
    end else begin
      check("tx_grant_idle", req_grant, 0);
      check("tx_data_hold", uart_tx_data, last_data);
      if (rv != 0 && !busy_e && !tx_out_e) idle_wait++;
      else idle_wait = 0;
      if (idle_wait > max_idle) max_idle = idle_wait;
    end
    check("rx_clear", uart_rx_ready_clear, exp_clear);
    check("rx_valid", rx_valid, rxq.size() > 0);
    if (rxq.size() > 0) check("rx_data", rx_data, rxq[0]);
    check("rx_overflow", rx_overflow, m_ovf);
    // Uart transmitter: busy rises the cycle after the strobe and lasts frame_len cycles.
    if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) begin uart_tx_busy = 1'b0; tx_out = 0; end
    end
    if (start_pending) begin uart_tx_busy = 1'b1; busy_cnt = frame_len; start_pending = 0; end
    if (uart_tx_strobe) start_pending = 1;
  endtask

  task automatic rx_present(input logic [7:0] b);
    uart_rx_data = b; uart_rx_ready = 1'b1; rx_new = 1'b1;
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_present(b); tick(); tick();
  endtask

  task automatic rx_drain();
    for (int i = 0; i < DEPTH + 4 && rx_valid; i++) begin
      rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    end
    check("rx_drain_empty", rx_valid, 0);
  endtask

  task automatic wait_tx_idle();
    for (int i = 0; i < 300; i++) begin
      if (!uart_tx_busy && !tx_out && !start_pending) break;
      tick();
    end
    check("tx_idle_timeout", tx_out, 0);
    tick(); tick(); tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; req_valid = '0; req_data = '0; uart_tx_busy = 1'b0;
    uart_rx_data = '0; uart_rx_ready = 1'b0; rx_pop = 1'b0; rx_overflow_clear = 1'b0;
    rx_new = 0; busy_cnt = 0; start_pending = 0; frame_len = 4; max_idle = 0; n_strobes = 0;
    rr_exp = '{8'h10, 8'h20, 8'h30, 8'h10};
    tick(); tick();
    check("reset_rx_valid", rx_valid, 0);
    check("reset_rx_overflow", rx_overflow, 0);
    check("reset_rx_clear", uart_rx_ready_clear, 0);
    reset_n = 1'b1;
    tick();

    // Round-robin with all requesters continuously pending
    req_data = {8'h30, 8'h20, 8'h10};
    req_valid = '1;
    for (int i = 0; i < 400 && got.size() < 4; i++) begin
      tick();
      if (uart_tx_strobe) got.push_back(uart_tx_data);
    end
    req_valid = '0;
    check("rr_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) check("rr_seq", got[i], rr_exp[i]);

    // Single-cycle latency from req_valid to strobe/grant
    wait_tx_idle();
    lat_b = 8'($urandom);
    req_data[23:16] = lat_b;
    req_valid = 3'b100;
    check("lat_pre_strobe", uart_tx_strobe, 0);
    tick();
    check("lat_strobe", uart_tx_strobe, 1);
    check("lat_grant", req_grant, 3'b100);
    check("lat_data", uart_tx_data, lat_b);
    req_valid = '0;
    tick();
    check("lat_strobe_drop", uart_tx_strobe, 0);
    check("lat_grant_drop", req_grant, 0);

    // Reset while the uart is mid-frame
    wait_tx_idle();
    frame_len = 10;
    req_data[7:0] = 8'h41;
    req_valid = 3'b001;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (uart_tx_strobe) break;
    end
    check("rstmid_first_strobe", uart_tx_strobe, 1);
    for (int i = 0; i < 20 && !uart_tx_busy; i++) tick();
    tick();
    reset_n = 1'b0;
    tick();
    check("rstmid_strobe", uart_tx_strobe, 0);
    check("rstmid_grant", req_grant, 0);
    check("rstmid_tx_data", uart_tx_data, 0);
    check("rstmid_rx_clear", uart_rx_ready_clear, 0);
    reset_n = 1'b1;
    nbusy = 0;
    for (int i = 0; i < 50 && uart_tx_busy; i++) begin
      tick();
      if (uart_tx_strobe) nbusy++;
    end
    check("rstmid_no_strobe_while_busy", nbusy, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (uart_tx_strobe) break;
    end
    check("rstmid_regrant", req_grant, 3'b001);
    check("rstmid_redata", uart_tx_data, 8'h41);
    req_valid = '0;
    wait_tx_idle();

    // Uart flag held through the clear cycle must be captured once
    rx_present(8'h5A);
    nclr = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (uart_rx_ready_clear) nclr++;
    end
    check("dbl_clear_pulses", nclr, 1);
    check("dbl_valid", rx_valid, 1);
    check("dbl_data", rx_data, 8'h5A);
    rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    check("dbl_single_entry", rx_valid, 0);

    // Overflow: one byte more than capacity
    for (int b = 1; b <= DEPTH + 1; b++) rx_push(8'(b));
    check("ovf_set", rx_overflow, 1);
    check("ovf_valid", rx_valid, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check("ovf_pop_data", rx_data, i + 1);
      rx_pop = 1'b1; tick(); rx_pop = 1'b0;
    end
    check("ovf_drained", rx_valid, 0);
    check("ovf_sticky", rx_overflow, 1);
    rx_overflow_clear = 1'b1; tick(); rx_overflow_clear = 1'b0;
    check("ovf_cleared", rx_overflow, 0);

    // Full buffer with push and pop in the same cycle
    for (int i = 0; i < DEPTH; i++) rx_push(8'(8'h60 + i));
    check("fullpp_pre_ovf", rx_overflow, 0);
    rx_present(8'hAA);
    rx_pop = 1'b1; tick(); rx_pop = 1'b0; tick();
    check("fullpp_no_ovf", rx_overflow, 0);
    npop = 0; lastb = 8'h00;
    while (rx_valid && npop < DEPTH + 4) begin
      lastb = rx_data;
      rx_pop = 1'b1; tick(); rx_pop = 1'b0;
      npop++;
    end
    check("fullpp_count", npop, DEPTH);
    check("fullpp_last", lastb, 8'hAA);

    // New overflow beats a same-cycle clear
    for (int i = 0; i < DEPTH; i++) rx_push(8'(8'h70 + i));
    rx_present(8'hEE);
    rx_overflow_clear = 1'b1; tick(); rx_overflow_clear = 1'b0; tick();
    check("ovf_beats_clear", rx_overflow, 1);
    rx_drain();
    rx_overflow_clear = 1'b1; tick(); rx_overflow_clear = 1'b0;

    // Randomized traffic on both paths
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_grant[i]) req_valid[i] = 1'b0;
        else if (!req_valid[i] && $urandom_range(3) == 0) begin
          req_data[8*i +: 8] = 8'($urandom);
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(99) == 0) req_valid[i] = 1'b0;
      end
      if (!uart_rx_ready && $urandom_range(4) == 0) rx_present(8'($urandom));
      rx_pop = ($urandom_range(2) == 0);
      rx_overflow_clear = ($urandom_range(19) == 0);
      if (busy_cnt == 0 && !start_pending) frame_len = $urandom_range(1, 12);
      tick();
    end
    req_valid = '0; rx_pop = 1'b0; rx_overflow_clear = 1'b0;
    wait_tx_idle();
    check("tx_stall", max_idle > 2, 0);
    check("tx_activity", n_strobes > 50, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
